// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan driver.
// Includes the gamma-2.2 table used when HUB75_GAMMA_EN is defined.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    localparam int R_MSB     = 23;
    localparam int G_MSB     = 15;
    localparam int B_MSB     = 7;
    localparam int ROW_FIELD = 5;
    localparam int COL_FIELD = 6;

    typedef logic [255:0][7:0] gamma_lut_t;

    // t^2.2 is approximated as 0.8*t^2 + 0.2*t^3, rounded to nearest.
    function automatic gamma_lut_t build_gamma_lut();
        gamma_lut_t lut;
        int         num;
        for (int i = 0; i < 256; i++) begin
            num    = 4 * i * i * 255 + i * i * i;
            lut[i] = 8'((num + 162562) / 325125);
        end
        return lut;
    endfunction

    localparam gamma_lut_t GAMMA_LUT = build_gamma_lut();

    function automatic logic [7:0] gamma22(input logic [7:0] x);
        return GAMMA_LUT[x];
    endfunction

endpackage

// File: rtl/hub75_bitplane_slicer.sv
// Picks one BCM bit-plane out of a 24-bit RGB pixel (combinational).
// With HUB75_GAMMA_EN defined each channel is gamma-corrected first.
module hub75_bitplane_slicer
    import hub75_pkg::*;
#(
    parameter int PLANES = 4,
    parameter int PW     = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic [23:0]   i_pixel,
    input  logic [PW-1:0] i_plane,
    output logic [2:0]    o_bits
);

    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;
    logic [2:0] w_idx;

`ifdef HUB75_GAMMA_EN
    assign w_r = gamma22(i_pixel[R_MSB -: 8]);
    assign w_g = gamma22(i_pixel[G_MSB -: 8]);
    assign w_b = gamma22(i_pixel[B_MSB -: 8]);
`else
    assign w_r = i_pixel[R_MSB -: 8];
    assign w_g = i_pixel[G_MSB -: 8];
    assign w_b = i_pixel[B_MSB -: 8];
`endif

    // Plane 0 is the lowest of the top PLANES bits of each channel.
    assign w_idx  = 3'(8 - PLANES) + 3'(i_plane);
    assign o_bits = {w_r[w_idx], w_g[w_idx], w_b[w_idx]};

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan panel driver with binary-coded modulation.
// Define HUB75_GAMMA_EN to gamma-correct pixels before plane slicing.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS        = 64,
    parameter int SCAN_ROWS   = 16,
    parameter int PLANES      = 4,
    parameter int BASE_TICKS  = 8,
    parameter int BLANK_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [11:0] pixel_addr,
    input  logic [23:0] pixel_data,
    output logic        hub_r1,
    output logic        hub_g1,
    output logic        hub_b1,
    output logic        hub_r2,
    output logic        hub_g2,
    output logic        hub_b2,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic [3:0]  hub_addr,
    output logic        frame_start
);

    localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW       = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
    localparam int PW       = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DISP_MAX = BASE_TICKS << (PLANES - 1);
    localparam int TW       = $clog2(((DISP_MAX > BLANK_TICKS) ? DISP_MAX : BLANK_TICKS) + 1);

    state_t          r_state, w_state_next;
    logic [1:0]      r_phase, w_phase_next;
    logic [CW-1:0]   r_col, w_col_next;
    logic [RW-1:0]   r_row, w_row_next;
    logic [PW-1:0]   r_plane, w_plane_next;
    logic [TW-1:0]   r_tick, w_tick_next;
    logic [TW-1:0]   w_disp_last;
    logic            w_frame_wrap;

    logic [11:0]     r_pixel_addr, w_pixel_addr_next;
    logic [2:0]      r_upper, w_upper_next;
    logic [5:0]      r_colour, w_colour_next;
    logic            r_hclk, w_hclk_next;
    logic            r_lat, w_lat_next;
    logic            r_oe_n, w_oe_n_next;
    logic [3:0]      r_hub_addr, w_hub_addr_next;
    logic            r_fs, w_fs_next;
    logic [2:0]      w_slice;
    logic [ROW_FIELD-1:0] w_row_field;

    hub75_bitplane_slicer #(
        .PLANES (PLANES),
        .PW     (PW)
    ) u_slicer (
        .i_pixel (pixel_data),
        .i_plane (r_plane),
        .o_bits  (w_slice)
    );

    assign w_disp_last = (TW'(BASE_TICKS) << r_plane) - TW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_tick       <= '0;
            r_pixel_addr <= '0;
            r_upper      <= '0;
            r_colour     <= '0;
            r_hclk       <= 1'b0;
            r_lat        <= 1'b0;
            r_oe_n       <= 1'b1;
            r_hub_addr   <= '0;
            r_fs         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_col        <= w_col_next;
            r_row        <= w_row_next;
            r_plane      <= w_plane_next;
            r_tick       <= w_tick_next;
            r_pixel_addr <= w_pixel_addr_next;
            r_upper      <= w_upper_next;
            r_colour     <= w_colour_next;
            r_hclk       <= w_hclk_next;
            r_lat        <= w_lat_next;
            r_oe_n       <= w_oe_n_next;
            r_hub_addr   <= w_hub_addr_next;
            r_fs         <= w_fs_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_plane_next = r_plane;
        w_tick_next  = r_tick;
        w_frame_wrap = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = SHIFT;
                    w_phase_next = '0;
                    w_col_next   = '0;
                    w_row_next   = '0;
                    w_plane_next = '0;
                    w_tick_next  = '0;
                    w_frame_wrap = 1'b1;
                end
            end
            SHIFT: begin
                w_phase_next = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    if (r_col == CW'(COLS - 1)) begin
                        w_state_next = BLANK;
                        w_col_next   = '0;
                        w_tick_next  = '0;
                    end else begin
                        w_col_next = r_col + CW'(1);
                    end
                end
            end
            BLANK: begin
                if (r_tick == TW'(BLANK_TICKS - 1)) begin
                    w_state_next = LATCH;
                    w_tick_next  = '0;
                end else begin
                    w_tick_next = r_tick + TW'(1);
                end
            end
            LATCH: begin
                w_state_next = DISPLAY;
                w_tick_next  = '0;
            end
            DISPLAY: begin
                if (r_tick == w_disp_last) begin
                    w_tick_next = '0;
                    if (r_plane == PW'(PLANES - 1)) begin
                        w_plane_next = '0;
                        if (r_row == RW'(SCAN_ROWS - 1)) begin
                            w_row_next   = '0;
                            w_frame_wrap = 1'b1;
                        end else begin
                            w_row_next = r_row + RW'(1);
                        end
                    end else begin
                        w_plane_next = r_plane + PW'(1);
                    end
                    if (enable) begin
                        w_state_next = SHIFT;
                        w_phase_next = '0;
                        w_col_next   = '0;
                    end else begin
                        // Stopping discards the scan position; restart is a fresh frame.
                        w_state_next = IDLE;
                        w_row_next   = '0;
                        w_plane_next = '0;
                        w_frame_wrap = 1'b0;
                    end
                end else begin
                    w_tick_next = r_tick + TW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_oe_n_next     = (w_state_next != DISPLAY);
        w_lat_next      = (w_state_next == LATCH);
        w_hclk_next     = (w_state_next == SHIFT) && (w_phase_next == 2'd3);
        w_fs_next       = (w_state_next == SHIFT) && w_frame_wrap;
        w_hub_addr_next = r_hub_addr;
        if ((r_state == SHIFT) && (w_state_next == BLANK)) begin
            w_hub_addr_next = 4'(r_row);
        end
        w_row_field = (w_phase_next == 2'd0) ? ROW_FIELD'(w_row_next)
                                             : ROW_FIELD'(w_row_next) + ROW_FIELD'(SCAN_ROWS);
        w_pixel_addr_next = r_pixel_addr;
        if (w_state_next == SHIFT) begin
            w_pixel_addr_next = {1'b0, w_row_field, COL_FIELD'(w_col_next)};
        end
        w_upper_next  = ((r_state == SHIFT) && (r_phase == 2'd0)) ? w_slice : r_upper;
        w_colour_next = ((r_state == SHIFT) && (r_phase == 2'd1)) ? {r_upper, w_slice} : r_colour;
    end

    assign pixel_addr  = r_pixel_addr;
    assign hub_r1      = r_colour[5];
    assign hub_g1      = r_colour[4];
    assign hub_b1      = r_colour[3];
    assign hub_r2      = r_colour[2];
    assign hub_g2      = r_colour[1];
    assign hub_b2      = r_colour[0];
    assign hub_clk     = r_hclk;
    assign hub_lat     = r_lat;
    assign hub_oe_n    = r_oe_n;
    assign hub_addr    = r_hub_addr;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: each row-plane is one transaction
// (64 shifted columns, latch row, display width) predicted from the image.
module tb_hub75_scan_driver;

    localparam int COLS      = 64;
    localparam int SCAN_ROWS = 16;
    localparam int PLANES    = 4;
    localparam int BASE      = 8;
    localparam int BLANKT    = 2;
    localparam int PREFIX    = 4 * COLS + BLANKT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] pixel_addr;
    logic [23:0] pixel_data;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic        hub_clk, hub_lat, hub_oe_n, frame_start;
    logic [3:0]  hub_addr;

    logic [23:0] img [0:2*SCAN_ROWS-1][0:COLS-1];
    assign pixel_data = img[pixel_addr[10:6]][pixel_addr[5:0]];

    hub75_scan_driver dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pixel_addr  (pixel_addr),
        .pixel_data  (pixel_data),
        .hub_r1      (hub_r1),
        .hub_g1      (hub_g1),
        .hub_b1      (hub_b1),
        .hub_r2      (hub_r2),
        .hub_g2      (hub_g2),
        .hub_b2      (hub_b2),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe_n    (hub_oe_n),
        .hub_addr    (hub_addr),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  row;
        logic [31:0] len;
        logic [63:0] r1, g1, b1, r2, g2, b2;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    // Reference: plane p of channel X shows bit X[8-PLANES+p]; rows r and r+16 pair up.
    function automatic txn_t model(input int row, input int plane);
        txn_t        t;
        logic [23:0] u, l;
        int          b;
        t     = '0;
        t.row = 4'(row);
        t.len = 32'(BASE << plane);
        b     = 8 - PLANES + plane;
        for (int c = 0; c < COLS; c++) begin
            u = img[row][c];
            l = img[row + SCAN_ROWS][c];
            t.r1[c] = u[16 + b];
            t.g1[c] = u[8 + b];
            t.b1[c] = u[b];
            t.r2[c] = l[16 + b];
            t.g2[c] = l[8 + b];
            t.b2[c] = l[b];
        end
        return t;
    endfunction

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model(i / PLANES, i % PLANES));
    endtask

    function automatic int start_off(input int i);
        int s = 0;
        for (int j = 0; j < i; j++) s += PREFIX + (BASE << (j % PLANES));
        return s;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 2 * SCAN_ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 24'($urandom);
    endtask

    task automatic fill_stripes();
        for (int r = 0; r < 2 * SCAN_ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = (r < SCAN_ROWS) ? 24'hFF0000 : 24'h0000FF;
    endtask

    task automatic fill_a0();
        for (int r = 0; r < 2 * SCAN_ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = {8'hA0, 16'($urandom)};
    endtask

    task automatic wait_fs(input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1;
        end
        chk(nm, 384'(seen), 384'(1));
    endtask

    task automatic wait_idle();
        bit saw_low = 0;
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!hub_oe_n) saw_low = 1;
            else if (saw_low) done = 1;
        end
        chk("idle_reached", 384'(done), 384'(1));
        repeat (20) @(negedge clk);
        chk("idle_oe_n", 384'(hub_oe_n), 384'(1));
        chk("idle_hub_clk", 384'(hub_clk), 384'(0));
        chk("idle_lat", 384'(hub_lat), 384'(0));
        chk("queue_drained", 384'(exp_q.size()), 384'(0));
    endtask

    // Run n row-planes from a fresh frame start, then drop enable mid-SHIFT of the last.
    task automatic run_rps(input int n, input string nm);
        push_n(n);
        enable = 1'b1;
        wait_fs(400, nm);
        repeat (start_off(n - 1) + 100) @(negedge clk);
        enable = 1'b0;
        wait_idle();
    endtask

    task automatic chk_blank_outputs(input string pfx);
        chk({pfx, "_oe_n"}, 384'(hub_oe_n), 384'(1));
        chk({pfx, "_lat"}, 384'(hub_lat), 384'(0));
        chk({pfx, "_hub_clk"}, 384'(hub_clk), 384'(0));
        chk({pfx, "_frame_start"}, 384'(frame_start), 384'(0));
        chk({pfx, "_colour"}, 384'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 384'(0));
        chk({pfx, "_pixel_addr"}, 384'(pixel_addr), 384'(0));
        chk({pfx, "_hub_addr"}, 384'(hub_addr), 384'(0));
    endtask

    // Monitor: assembles one transaction per display period and scores it.
    logic [63:0] a_r1, a_g1, a_b1, a_r2, a_g2, a_b2;
    int   edges, lat_cnt, lat_pos, first_low, disp, seg_start;
    logic [3:0] lat_addr, addr_prev;
    bit   addr_bad, oe_prev_low, hclk_prev, fs_prev;

    task automatic clear_acc();
        a_r1 = '0; a_g1 = '0; a_b1 = '0; a_r2 = '0; a_g2 = '0; a_b2 = '0;
        edges = 0; lat_cnt = 0; lat_pos = -1; first_low = -1; disp = 0;
        lat_addr = '0; addr_bad = 0;
    endtask

    initial begin
        txn_t e;
        clear_acc();
        seg_start = 0;
        addr_prev = '0;
        oe_prev_low = 0; hclk_prev = 0; fs_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                clear_acc();
                oe_prev_low = 0; hclk_prev = 0; fs_prev = 0;
            end else begin
                if (hub_oe_n && oe_prev_low) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", 384'(1), 384'(0));
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn row=%0d len=%0d edges=%0d disp=%0d", e.row, e.len, edges, disp);
                        chk("row_addr", 384'(lat_addr), 384'(e.row));
                        chk("clk_edges", 384'(edges), 384'(COLS));
                        chk("colour", {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2},
                            {e.r1, e.g1, e.b1, e.r2, e.g2, e.b2});
                        chk("lat_pulses", 384'(lat_cnt), 384'(1));
                        chk("lat_pos", 384'(lat_pos), 384'(PREFIX - 1));
                        chk("blank_prefix", 384'(first_low), 384'(PREFIX));
                        chk("display_len", 384'(disp), 384'(e.len));
                        chk("addr_ok", 384'(addr_bad), 384'(0));
                    end
                    seg_start = cyc;
                    clear_acc();
                end
                if (frame_start) begin
                    chk("fs_width", 384'(fs_prev), 384'(0));
                    seg_start = cyc;
                    clear_acc();
                end
                if (hub_clk && !hclk_prev) begin
                    if (edges < COLS) begin
                        a_r1[edges] = hub_r1; a_g1[edges] = hub_g1; a_b1[edges] = hub_b1;
                        a_r2[edges] = hub_r2; a_g2[edges] = hub_g2; a_b2[edges] = hub_b2;
                    end
                    edges++;
                end
                if (hub_lat) begin
                    lat_cnt++;
                    lat_addr = hub_addr;
                    lat_pos  = cyc - seg_start;
                end
                if (!hub_oe_n) begin
                    if (disp == 0) first_low = cyc - seg_start;
                    disp++;
                    if (hub_addr != addr_prev) addr_bad = 1;
                end
                if (pixel_addr[11]) addr_bad = 1;
                oe_prev_low = !hub_oe_n;
                hclk_prev   = hub_clk;
                fs_prev     = frame_start;
                addr_prev   = hub_addr;
            end
        end
    end

    initial begin
        int  t0;
        bit  in_disp;
        fill_random();
        enable = 1'b1;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        chk_blank_outputs("reset");

        // Full frame of a random image, then frame 1 stopped during row 5.
        push_n(SCAN_ROWS * PLANES);
        rst = 1'b1;
        wait_fs(20, "fs_first");
        t0 = cyc;
        wait_fs(20000, "fs_second");
        chk("frame_period", 384'(cyc - t0), 384'(SCAN_ROWS * (PLANES * PREFIX + BASE * 15)));
        push_n(5 * PLANES + 1);
        repeat (start_off(5 * PLANES) + 100) @(negedge clk);
        enable = 1'b0;
        wait_idle();

        fill_stripes();
        run_rps($urandom_range(3, 8), "fs_restart_stripes");

        fill_a0();
        run_rps($urandom_range(4, 8), "fs_restart_a0");

        // Asynchronous reset while the panel is lit.
        fill_random();
        enable = 1'b1;
        wait_fs(400, "fs_pre_reset");
        in_disp = 0;
        for (int i = 0; i < 400 && !in_disp; i++) begin
            @(negedge clk);
            if (!hub_oe_n) in_disp = 1;
        end
        chk("display_reached", 384'(in_disp), 384'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_blank_outputs("async_reset");
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b1;
        run_rps($urandom_range(3, 6), "fs_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Downstream consumer of the temperature pixel generator; drives a 64x32 HUB75 RGB panel at 1/16 scan.
- Issues `pixel_addr` `{1'b0, row[4:0], col[5:0]}`, captures the returned 24-bit `pixel_data`, slices it into bit-planes and shifts the upper and lower half-rows out on the six colour lines.
- Generates panel clock, latch, output-enable and row address; uses binary-coded modulation (BCM) for colour depth.

Parameters:
- COLS, 64, columns per panel row; power of two, ≤64.
- SCAN_ROWS, 16, multiplexed row pairs; panel height = 2*SCAN_ROWS.
- PLANES, 4, BCM planes; uses the top PLANES bits of each 8-bit channel.
- BASE_TICKS, 8, display clocks for plane 0; plane p displays BASE_TICKS<<p.
- BLANK_TICKS, 2, clocks with OE off before the latch, minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run scanning; sampled at row-plane boundaries.
- pixel_addr  out  12  `{1'b0, row[4:0], col[5:0]}` to the pixel generator.
- pixel_data  in  24  R[23:16] G[15:8] B[7:0]; combinational response to `pixel_addr`.
- hub_r1, hub_g1, hub_b1  out  1 each  upper-half colour bits.
- hub_r2, hub_g2, hub_b2  out  1 each  lower-half colour bits.
- hub_clk  out  1  panel shift clock.
- hub_lat  out  1  panel latch, active high.
- hub_oe_n  out  1  panel output enable, active low.
- hub_addr  out  4  scan row (A..D).
- frame_start  out  1  one-cycle pulse at the start of row 0, plane 0.

Behaviour:
- Reset (rst=0, async):
  - hub_oe_n=1; all other outputs 0.
  - state=IDLE; row, plane and column counters 0.
  - Reset mid-operation blanks the panel immediately; no partial latch.
- States: IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> SHIFT or IDLE.
- IDLE:
  - hub_oe_n=1.
  - If enable=1: go to SHIFT at row 0, plane 0; frame_start=1 in that transition cycle.
- SHIFT: 4 phases per column c; hub_oe_n=1 throughout.
  - Phase 0: pixel_addr = upper row r, column c.
  - Phase 1: pixel_addr = lower row r+SCAN_ROWS; register the upper colour bits.
  - Phase 2: register the lower colour bits; hub_r1..hub_b2 update; hub_clk=0.
  - Phase 3: hub_clk=1; panel samples on this rising edge.
  - Data is valid one cycle after `pixel_addr` changes (generator is combinational); the driver samples at the clock edge ending that cycle.
  - Colour bit for plane p, channel X = X[8-PLANES+p].
  - After column COLS-1 phase 3: hub_clk returns to 0; go to BLANK. SHIFT lasts 4*COLS cycles.
- BLANK:
  - hub_oe_n=1 for BLANK_TICKS cycles.
  - hub_addr takes the new row r on the first BLANK cycle; the row address changes only while blanked.
- LATCH: hub_lat=1 for exactly one cycle; hub_oe_n=1.
- DISPLAY:
  - hub_oe_n=0 for BASE_TICKS<<plane cycles.
  - Then advance plane; on plane wrap advance row; on row wrap (r=SCAN_ROWS-1, last plane) return to row 0 and pulse frame_start on the transition into SHIFT.
  - If enable=0 at the end of DISPLAY: go to IDLE with hub_oe_n=1; the next start is a full frame restart.
- Order: row outer, plane inner.
- Cycles per row-plane = 4*COLS + BLANK_TICKS + 1 + (BASE_TICKS<<p).
- Counter widths: $clog2 of each bound; display counter wide enough for BASE_TICKS<<(PLANES-1).
- enable is ignored except in IDLE and at the end of DISPLAY.
- pixel_addr[11] is always 0. pixel_addr holds its last value outside SHIFT.

Optional Feature:
- Macro: HUB75_GAMMA_EN.
- When defined: each 8-bit channel passes through a 256-entry gamma-2.2 LUT (constant function in the package) before plane slicing. The LUT sits combinationally in front of the capture registers, so latency is unchanged.
- When undefined: raw channel bits are sliced directly.
- Timing and all control outputs are identical either way.

Decomposition:
- Package hub75_pkg:
  - state enum (IDLE, SHIFT, BLANK, LATCH, DISPLAY).
  - channel slice localparams (R_MSB=23, G_MSB=15, B_MSB=7).
  - gamma LUT function.
  - ROW_FIELD/COL_FIELD address widths (5/6).
- Sub-module hub75_bitplane_slicer: combinational; inputs 24-bit pixel and plane index; outputs 3 colour bits; contains the optional gamma path.

Test Plan:
- Reset held then released with enable=1, defaults: frame_start pulses once; hub_oe_n=1 for the first 259 cycles; exactly 64 hub_clk rising edges, then hub_lat high 1 cycle, then hub_oe_n=0 for 8 cycles.
- Frame length, defaults: frame_start period = 16*(4*259+8*15) = 18496 cycles; hub_addr steps 0..15; display widths 8/16/32/64 per row.
- Stub pixel_data = 24'hFF0000 when addr row<16, else 24'h0000FF: every shifted column has r1=1 g1=b1=0, b2=1 r2=g2=0, on all planes.
- pixel_data R=8'b1010_0000 (PLANES=4, gamma off): r1 per plane 0..3 = 0,1,0,1.
- Deassert enable mid-SHIFT of row 5: row 5 completes through DISPLAY, then IDLE with hub_oe_n=1. Reassert: frame_start pulses and hub_addr returns to 0.
- Assert rst=0 during DISPLAY: hub_oe_n=1 and hub_lat=hub_clk=0 in the same cycle without a clock edge; after release, behaviour matches the first scenario.
